// File: rtl/simon32_64_decrypt_if.sv
// rtl/simon32_64_decrypt_if.sv - ciphertext/key request and plaintext response bundle
//
// Purpose: groups the request (ciphertext + key) and response (plaintext)
// valid/ready handshakes of the Simon32/64 decryption core.
// Signals:
//   in_valid   master->slave  ciphertext/key offered
//   in_ready   slave->master  core can accept
//   ciphertext master->slave  [31:16] = x, [15:0] = y
//   key        master->slave  {k3, k2, k1, k0}
//   out_valid  slave->master  plaintext valid, held until accepted
//   out_ready  master->slave  downstream accepts plaintext
//   plaintext  slave->master  [31:16] = x, [15:0] = y
interface simon32_64_decrypt_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ciphertext;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] plaintext;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/simon32_64_decrypt.sv
// rtl/simon32_64_decrypt.sv - iterative Simon32/64 decryption core with round-key cache
//
// Purpose: accepts one ciphertext/key pair, expands the 32-word key schedule
// (one word per cycle, skipped on a cache hit), then runs 32 inverse rounds
// (k31 down to k0, one per cycle) and presents the plaintext until accepted.
// Ports:
//   clk    input  clock
//   reset  input  synchronous, active-high reset
//   bus    slave  request/response handshake bundle (simon32_64_decrypt_if)
module simon32_64_decrypt #(
  parameter bit          KEY_CACHE = 1'b1,
  parameter logic [31:0] Z_SEQ     = 32'hFA2561CD
) (
  input  logic                 clk,
  input  logic                 reset,
  simon32_64_decrypt_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;          // schedule index in EXPAND, round index in DECRYPT
  logic        tab_valid_q, tab_valid_d;
  logic [15:0] rk_q [32];
  logic [63:0] key_q;
  logic [15:0] x_q, y_q;
  logic [31:0] pt_q;

  logic        accept;
  logic        hit;
  logic [15:0] t_a, t_b, k_new;
  logic [4:0]  zj;
  logic [15:0] rk_cur, f_y, y_new;

  function automatic logic [15:0] rol1(input logic [15:0] a); return {a[14:0], a[15]};    endfunction
  function automatic logic [15:0] rol2(input logic [15:0] a); return {a[13:0], a[15:14]}; endfunction
  function automatic logic [15:0] rol8(input logic [15:0] a); return {a[7:0],  a[15:8]};  endfunction
  function automatic logic [15:0] ror1(input logic [15:0] a); return {a[0],    a[15:1]};  endfunction
  function automatic logic [15:0] ror3(input logic [15:0] a); return {a[2:0],  a[15:3]};  endfunction

  assign hit = KEY_CACHE && tab_valid_q && (bus.key == key_q);

  // Key schedule word for index idx_q (valid while in EXPAND, idx 4..31)
  always_comb begin
    t_a   = ror3(rk_q[idx_q - 5'd1]) ^ rk_q[idx_q - 5'd3];
    t_b   = t_a ^ ror1(t_a);
    zj    = idx_q - 5'd4;
    k_new = ~rk_q[idx_q - 5'd4] ^ t_b ^ {15'd0, Z_SEQ[5'd31 - zj]} ^ 16'h0003;
  end

  // Inverse round: x_new = y, y_new = x ^ f(y) ^ k
  always_comb begin
    rk_cur = rk_q[idx_q];
    f_y    = (rol1(y_q) & rol8(y_q)) ^ rol2(y_q);
    y_new  = x_q ^ f_y ^ rk_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 5'd0;
      tab_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tab_valid_q <= tab_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tab_valid_d   = tab_valid_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept = 1'b1;
          if (hit) begin
            state_d = DECRYPT;
            idx_d   = 5'd31;
          end else begin
            tab_valid_d = 1'b0;
            state_d     = EXPAND;
            idx_d       = 5'd4;
          end
        end
      end
      EXPAND: begin
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          tab_valid_d = 1'b1;
          state_d     = DECRYPT;
          idx_d       = 5'd31;
        end
      end
      DECRYPT: begin
        idx_d = idx_q - 5'd1;
        if (idx_q == 5'd0) begin
          state_d = DONE;
          idx_d   = 5'd0;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round-key table carries no reset; tab_valid_q qualifies its contents
  always_ff @(posedge clk) begin
    if (accept) begin
      rk_q[0] <= bus.key[15:0];
      rk_q[1] <= bus.key[31:16];
      rk_q[2] <= bus.key[47:32];
      rk_q[3] <= bus.key[63:48];
    end else if (state_q == EXPAND) begin
      rk_q[idx_q] <= k_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= 64'd0;
      x_q   <= 16'd0;
      y_q   <= 16'd0;
      pt_q  <= 32'd0;
    end else if (accept) begin
      key_q <= bus.key;
      x_q   <= bus.ciphertext[31:16];
      y_q   <= bus.ciphertext[15:0];
    end else if (state_q == DECRYPT) begin
      x_q <= y_q;
      y_q <= y_new;
      if (idx_q == 5'd0) pt_q <= {y_q, y_new};
    end
  end

  assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_simon32_64_decrypt.sv
// tb/tb_simon32_64_decrypt.sv - randomized round-trip bench for simon32_64_decrypt
module tb_simon32_64_decrypt;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simon32_64_decrypt_if b1();
  simon32_64_decrypt_if b0();

  simon32_64_decrypt #(.KEY_CACHE(1'b1)) dut    (.clk(clk), .reset(reset), .bus(b1));
  simon32_64_decrypt #(.KEY_CACHE(1'b0)) dut_nc (.clk(clk), .reset(reset), .bus(b0));

  localparam logic [31:0] ZC = 32'hFA2561CD;

  int          n_pass  = 0;
  int          n_total = 0;
  bit          cache_valid = 1'b0;
  logic [63:0] cache_key   = 64'd0;
  logic [15:0] rk [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] rl(input logic [15:0] a, input int n);
    logic [31:0] w;
    w = {16'h0, a};
    w = (w << n) | (w >> (16 - n));
    return w[15:0];
  endfunction

  function automatic logic [15:0] fr(input logic [15:0] a);
    return (rl(a, 1) & rl(a, 8)) ^ rl(a, 2);
  endfunction

  task automatic expand_model(input logic [63:0] k);
    logic [15:0] t;
    logic [31:0] zs;
    rk[0] = k[15:0];
    rk[1] = k[31:16];
    rk[2] = k[47:32];
    rk[3] = k[63:48];
    for (int i = 4; i < 32; i++) begin
      t  = rl(rk[i-1], 13) ^ rk[i-3];
      t  = t ^ rl(t, 15);
      zs = (ZC >> (31 - (i - 4))) & 32'd1;
      rk[i] = ~rk[i-4] ^ t ^ zs[15:0] ^ 16'h0003;
    end
  endtask

  // Forward Simon32/64 encryption using the expanded rk[]
  function automatic logic [31:0] encrypt(input logic [31:0] p);
    logic [15:0] x, y, tmp;
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 32; i++) begin
      tmp = x;
      x   = y ^ fr(x) ^ rk[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  task automatic drive(input logic v, input logic [63:0] k, input logic [31:0] ct);
    b1.in_valid = v;  b0.in_valid = v;
    b1.key = k;       b0.key = k;
    b1.ciphertext = ct; b0.ciphertext = ct;
  endtask

  task automatic set_oready(input logic r);
    b1.out_ready = r;
    b0.out_ready = r;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(b1.in_ready === 1'b1 && b0.in_ready === 1'b1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", 64'(n < 200), 64'd1);
  endtask

  task automatic run_txn(input logic [63:0] k, input logic [31:0] ct,
                         input logic [31:0] pt, input bit hold);
    int lat1, lat0, n, exp_lat;
    logic [31:0] p1, p0;
    exp_lat = (cache_valid && cache_key == k) ? 32 : 60;
    wait_idle();
    drive(1'b1, k, ct);
    set_oready(!hold);
    @(posedge clk); #1;
    drive(1'b0, {$urandom, $urandom}, $urandom);
    lat1 = -1; lat0 = -1; p1 = 32'd0; p0 = 32'd0; n = 0;
    while ((lat1 < 0 || lat0 < 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!hold && lat1 >= 0 && n == lat1 + 1) check("single_xfer", 64'(b1.out_valid), 64'd0);
      if (lat1 < 0 && b1.out_valid === 1'b1) begin lat1 = n; p1 = b1.plaintext; end
      if (lat0 < 0 && b0.out_valid === 1'b1) begin lat0 = n; p0 = b0.plaintext; end
    end
    check("lat_cache", 64'(lat1), 64'(exp_lat));
    check("lat_nocache", 64'(lat0), 64'd60);
    check("pt", 64'(p1), 64'(pt));
    check("pt_nocache", 64'(p0), 64'(pt));
    if (hold) begin
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        check("hold_valid", 64'(b1.out_valid), 64'd1);
        check("hold_pt", 64'(b1.plaintext), 64'(pt));
        check("hold_in_ready", 64'(b1.in_ready), 64'd0);
      end
      set_oready(1'b1);
      @(posedge clk); #1;
      check("xfer_valid", 64'({b1.out_valid, b0.out_valid}), 64'd0);
      check("xfer_in_ready", 64'({b1.in_ready, b0.in_ready}), 64'd3);
    end else begin
      @(posedge clk); #1;
      check("xfer_nocache", 64'({b0.out_valid, b0.in_ready}), 64'd1);
      check("idle_cache", 64'(b1.in_ready), 64'd1);
    end
    cache_valid = 1'b1;
    cache_key   = k;
  endtask

  // Reset is sampled at the nedge-th edge after the accepting edge
  task automatic run_abort(input logic [63:0] k, input logic [31:0] ct, input int nedge);
    wait_idle();
    drive(1'b1, k, ct);
    set_oready(1'b1);
    @(posedge clk); #1;
    drive(1'b0, 64'd0, 32'd0);
    repeat (nedge - 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", 64'({b1.out_valid, b0.out_valid}), 64'd0);
    check("abort_pt", 64'({b1.plaintext, b0.plaintext}), 64'd0);
    check("abort_in_ready", 64'({b1.in_ready, b0.in_ready}), 64'd3);
    cache_valid = 1'b0;
  endtask

  initial begin
    logic [63:0] kv, k, kprev;
    logic [31:0] pt, ct;
    drive(1'b0, 64'd0, 32'd0);
    set_oready(1'b1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_ready_valid", 64'({b1.in_ready, b1.out_valid, b0.in_ready, b0.out_valid}), 64'b1010);
    check("reset_pt", 64'({b1.plaintext, b0.plaintext}), 64'd0);

    kv = 64'h1918111009080100;
    run_txn(kv, 32'hC69BE9BB, 32'h65656877, 1'b0);
    run_txn(kv, 32'hC69BE9BB, 32'h65656877, 1'b0);
    run_txn(kv, 32'hC69BE9BB, 32'h65656877, 1'b1);

    run_abort(kv, 32'hC69BE9BB, 10);
    run_txn(kv, 32'hC69BE9BB, 32'h65656877, 1'b0);
    run_abort(kv, 32'hC69BE9BB, 15);
    run_txn(kv, 32'hC69BE9BB, 32'h65656877, 1'b0);

    kprev = kv;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) k = kprev;
      else k = {$urandom, $urandom};
      pt = $urandom;
      expand_model(k);
      ct = encrypt(pt);
      run_txn(k, ct, pt, (i % 97) == 13);
      kprev = k;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
